// File: rtl/cpu_latent_writeback.sv
// rtl/cpu_latent_writeback.sv - register-file write arbiter for main-pipeline and latent divider results
// Holds up to two late divide results and tracks which registers still await one.
module cpu_latent_writeback (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p4_wr_en,
  input  logic [4:0]  p4_wr_dest,
  input  logic [31:0] p4_wr_data,
  input  logic        div_valid,
  input  logic [4:0]  div_dest_reg,
  input  logic [31:0] div_result,
  input  logic        p3_div_start,
  input  logic [4:0]  p3_latent_dest,
  input  logic [4:0]  p2_src_a,
  input  logic [4:0]  p2_src_b,
  input  logic [4:0]  p2_dest,
  output logic        hazard_stall,
  output logic        div_issue_ok,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_dest,
  output logic [31:0] rf_wr_data,
  output logic [31:0] pending_mask,
  output logic [1:0]  buf_count,
  output logic        overflow_err
);

  logic [4:0]  fifo_dest_q [2];
  logic [31:0] fifo_data_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [31:0] mask_q, mask_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_dest_q, wr_dest_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        p4_take, div_ok, pop, bypass, push, push_ok;
  logic [4:0]  head_dest;
  logic [31:0] head_data;
  logic [31:0] set_vec, clr_vec;

  assign head_dest = fifo_dest_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // Dest-0 writes are treated as if they never arrived.
  assign p4_take = p4_wr_en && (p4_wr_dest != 5'd0);
  assign div_ok  = div_valid && (div_dest_reg != 5'd0);
  assign pop     = !p4_take && (count_q != 2'd0);
  assign bypass  = !p4_take && (count_q == 2'd0) && div_ok;
  assign push    = div_ok && !bypass;
  assign push_ok = push && !((count_q == 2'd2) && !pop);

  always_comb begin
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (p4_take) begin
      wr_en_d   = 1'b1;
      wr_dest_d = p4_wr_dest;
      wr_data_d = p4_wr_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_dest_d = head_dest;
      wr_data_d = head_data;
    end else if (bypass) begin
      wr_en_d   = 1'b1;
      wr_dest_d = div_dest_reg;
      wr_data_d = div_result;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (push && !push_ok);
  end

  // Clear lands on the same edge that launches the rf write; a coincident set wins.
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (p3_div_start && (p3_latent_dest != 5'd0)) set_vec[p3_latent_dest] = 1'b1;
    if (pop)    clr_vec[head_dest]    = 1'b1;
    if (bypass) clr_vec[div_dest_reg] = 1'b1;
    mask_d = (mask_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      ovf_q          <= 1'b0;
      mask_q         <= 32'd0;
      wr_en_q        <= 1'b0;
      wr_dest_q      <= 5'd0;
      wr_data_q      <= 32'd0;
      fifo_dest_q[0] <= 5'd0;
      fifo_dest_q[1] <= 5'd0;
      fifo_data_q[0] <= 32'd0;
      fifo_data_q[1] <= 32'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
      if (push_ok) begin
        fifo_dest_q[wr_ptr_q] <= div_dest_reg;
        fifo_data_q[wr_ptr_q] <= div_result;
      end
    end
  end

  function automatic logic hits(input logic [4:0] r, input logic [31:0] m,
                                input logic fwd, input logic [4:0] fdest);
    return (r != 5'd0) && (m[r] || (fwd && (fdest == r)));
  endfunction

  logic fwd_start;
  assign fwd_start = p3_div_start && (p3_latent_dest != 5'd0);

  assign hazard_stall = hits(p2_src_a, mask_q, fwd_start, p3_latent_dest) ||
                        hits(p2_src_b, mask_q, fwd_start, p3_latent_dest) ||
                        hits(p2_dest,  mask_q, fwd_start, p3_latent_dest);
  assign div_issue_ok = (count_q != 2'd2) && !div_valid;

  assign rf_wr_en     = wr_en_q;
  assign rf_wr_dest   = wr_dest_q;
  assign rf_wr_data   = wr_data_q;
  assign pending_mask = mask_q;
  assign buf_count    = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_cpu_latent_writeback.sv
// tb/tb_cpu_latent_writeback.sv - directed self-checking bench for cpu_latent_writeback
module tb_cpu_latent_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        p4_wr_en;
  logic [4:0]  p4_wr_dest;
  logic [31:0] p4_wr_data;
  logic        div_valid;
  logic [4:0]  div_dest_reg;
  logic [31:0] div_result;
  logic        p3_div_start;
  logic [4:0]  p3_latent_dest;
  logic [4:0]  p2_src_a, p2_src_b, p2_dest;
  logic        hazard_stall, div_issue_ok, rf_wr_en, overflow_err;
  logic [4:0]  rf_wr_dest;
  logic [31:0] rf_wr_data, pending_mask;
  logic [1:0]  buf_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  cpu_latent_writeback dut (
    .clock(clock), .reset_n(reset_n),
    .p4_wr_en(p4_wr_en), .p4_wr_dest(p4_wr_dest), .p4_wr_data(p4_wr_data),
    .div_valid(div_valid), .div_dest_reg(div_dest_reg), .div_result(div_result),
    .p3_div_start(p3_div_start), .p3_latent_dest(p3_latent_dest),
    .p2_src_a(p2_src_a), .p2_src_b(p2_src_b), .p2_dest(p2_dest),
    .hazard_stall(hazard_stall), .div_issue_ok(div_issue_ok),
    .rf_wr_en(rf_wr_en), .rf_wr_dest(rf_wr_dest), .rf_wr_data(rf_wr_data),
    .pending_mask(pending_mask), .buf_count(buf_count), .overflow_err(overflow_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    p4_wr_en = 0; p4_wr_dest = 0; p4_wr_data = 0;
    div_valid = 0; div_dest_reg = 0; div_result = 0;
    p3_div_start = 0; p3_latent_dest = 0;
    p2_src_a = 0; p2_src_b = 0; p2_dest = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    #1;
    chk("reset rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("reset pending_mask", pending_mask, 32'd0);
    chk("reset buf_count", {30'd0, buf_count}, 32'd0);
    chk("reset overflow_err", {31'd0, overflow_err}, 32'd0);
    chk("reset div_issue_ok", {31'd0, div_issue_ok}, 32'd1);
    chk("reset hazard_stall", {31'd0, hazard_stall}, 32'd0);
  endtask

  task automatic test_p4_write();
    p4_wr_en = 1; p4_wr_dest = 5; p4_wr_data = 32'h1234;
    tick();
    chk("p4 rf_wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("p4 rf_wr_dest", {27'd0, rf_wr_dest}, 32'd5);
    chk("p4 rf_wr_data", rf_wr_data, 32'h1234);
    p4_wr_dest = 0; p4_wr_data = 32'hDEAD;
    tick();
    chk("p4 dest0 rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    idle_inputs();
    tick();
    chk("idle rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
  endtask

  task automatic test_div_bypass();
    p3_div_start = 1; p3_latent_dest = 7; p2_src_a = 7;
    #1;
    chk("forward hazard p3 start", {31'd0, hazard_stall}, 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("bypass mask set", pending_mask, 32'h80);
    div_valid = 1; div_dest_reg = 7; div_result = 32'hFFFFFFF9;
    #1;
    chk("issue_ok low on div_valid", {31'd0, div_issue_ok}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("bypass rf_wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("bypass rf_wr_dest", {27'd0, rf_wr_dest}, 32'd7);
    chk("bypass rf_wr_data", rf_wr_data, 32'hFFFFFFF9);
    chk("bypass mask cleared", pending_mask, 32'd0);
    chk("bypass buf_count", {30'd0, buf_count}, 32'd0);
  endtask

  task automatic test_fifo_queue();
    p3_div_start = 1; p3_latent_dest = 3;
    tick();
    idle_inputs();
    p4_wr_en = 1; p4_wr_dest = 1; p4_wr_data = 32'h11;
    div_valid = 1; div_dest_reg = 3; div_result = 42;
    tick();
    div_valid = 0;
    chk("queue count c1", {30'd0, buf_count}, 32'd1);
    chk("queue dest c1", {27'd0, rf_wr_dest}, 32'd1);
    p4_wr_dest = 2; p4_wr_data = 32'h22;
    tick();
    chk("queue count c2", {30'd0, buf_count}, 32'd1);
    chk("queue dest c2", {27'd0, rf_wr_dest}, 32'd2);
    p4_wr_dest = 4; p4_wr_data = 32'h44;
    tick();
    chk("queue count c3", {30'd0, buf_count}, 32'd1);
    chk("queue mask held", pending_mask, 32'h8);
    idle_inputs();
    tick();
    chk("queue drain en", {31'd0, rf_wr_en}, 32'd1);
    chk("queue drain dest", {27'd0, rf_wr_dest}, 32'd3);
    chk("queue drain data", rf_wr_data, 32'd42);
    chk("queue drain count", {30'd0, buf_count}, 32'd0);
    chk("queue mask cleared", pending_mask, 32'd0);
  endtask

  task automatic test_hazard();
    p3_div_start = 1; p3_latent_dest = 9;
    tick();
    idle_inputs();
    p2_src_b = 9;
    #1;
    chk("hazard src_b", {31'd0, hazard_stall}, 32'd1);
    p2_src_b = 0;
    #1;
    chk("hazard zeros", {31'd0, hazard_stall}, 32'd0);
    p2_dest = 9; p2_src_a = 8;
    #1;
    chk("hazard dest", {31'd0, hazard_stall}, 32'd1);
    p2_dest = 0;
    #1;
    chk("no hazard other reg", {31'd0, hazard_stall}, 32'd0);
    // Completion and re-issue to the same register in one cycle: set must win.
    div_valid = 1; div_dest_reg = 9; div_result = 9;
    p3_div_start = 1; p3_latent_dest = 9;
    tick();
    idle_inputs();
    chk("set wins over clear", pending_mask, 32'h200);
    div_valid = 1; div_dest_reg = 9; div_result = 99;
    tick();
    idle_inputs();
    chk("mask cleared r9", pending_mask, 32'd0);
  endtask

  task automatic test_back_to_back();
    p4_wr_en = 1; p4_wr_dest = 1; p4_wr_data = 32'h1;
    div_valid = 1; div_dest_reg = 11; div_result = 32'hB;
    tick();
    div_valid = 0;
    chk("ovf count 1", {30'd0, buf_count}, 32'd1);
    tick();
    div_valid = 1; div_dest_reg = 12; div_result = 32'hC;
    tick();
    div_valid = 0;
    #1;
    chk("ovf count 2", {30'd0, buf_count}, 32'd2);
    chk("ovf issue_ok full", {31'd0, div_issue_ok}, 32'd0);
    chk("ovf not yet", {31'd0, overflow_err}, 32'd0);
    div_valid = 1; div_dest_reg = 13; div_result = 32'hD;
    tick();
    chk("ovf set", {31'd0, overflow_err}, 32'd1);
    chk("ovf count stays 2", {30'd0, buf_count}, 32'd2);
    p4_wr_en = 0;
    div_dest_reg = 14; div_result = 32'hE;
    tick();
    div_valid = 0;
    chk("push+pop count", {30'd0, buf_count}, 32'd2);
    chk("drain1 dest", {27'd0, rf_wr_dest}, 32'd11);
    chk("drain1 data", rf_wr_data, 32'hB);
    tick();
    chk("drain2 dest", {27'd0, rf_wr_dest}, 32'd12);
    chk("drain2 count", {30'd0, buf_count}, 32'd1);
    tick();
    chk("drain3 dest", {27'd0, rf_wr_dest}, 32'd14);
    chk("drain3 data", rf_wr_data, 32'hE);
    chk("drain3 count", {30'd0, buf_count}, 32'd0);
    tick();
    chk("drained en", {31'd0, rf_wr_en}, 32'd0);
    chk("ovf sticky", {31'd0, overflow_err}, 32'd1);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    p4_wr_en = 1; p4_wr_dest = 2; p4_wr_data = 32'h2;
    p3_div_start = 1; p3_latent_dest = 20;
    div_valid = 1; div_dest_reg = 21; div_result = 32'h21;
    tick();
    p3_div_start = 0;
    div_dest_reg = 22; div_result = 32'h22;
    tick();
    idle_inputs();
    chk("pre-reset count", {30'd0, buf_count}, 32'd2);
    chk("pre-reset mask", pending_mask, 32'h100000);
    #2;
    reset_n = 0;
    #1;
    chk("async rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("async mask", pending_mask, 32'd0);
    chk("async count", {30'd0, buf_count}, 32'd0);
    chk("async overflow", {31'd0, overflow_err}, 32'd0);
    tick();
    reset_n = 1;
    tick();
    chk("post-reset nothing drained", {31'd0, rf_wr_en}, 32'd0);
    p4_wr_en = 1; p4_wr_dest = 6; p4_wr_data = 32'h66;
    tick();
    idle_inputs();
    chk("resume dest", {27'd0, rf_wr_dest}, 32'd6);
    chk("resume data", rf_wr_data, 32'h66);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_p4_write();
        test_div_bypass();
        test_fifo_queue();
        test_hazard();
        test_back_to_back();
        test_async_reset();
      end
      begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        tests_failed++;
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
